// File: rtl/kyber_pkg.sv
// Shared Kyber datapath widths used by the client, the output serializer and the bus bridge.
package kyber_pkg;
  localparam int KYBER_BLK_W  = 256;
  localparam int KYBER_BUS_W  = 32;
  localparam int KYBER_NWORDS = KYBER_BLK_W / KYBER_BUS_W;
endpackage

// File: rtl/kyber_dout_serializer.sv
// Two-entry block buffer that streams 256-bit Kyber result blocks out as 32-bit words
// over valid/ready; blocks arriving with the buffer full and no pop in flight are dropped.
module kyber_dout_serializer
  import kyber_pkg::*;
#(
  parameter int BLK_W  = KYBER_BLK_W,
  parameter int WORD_W = KYBER_BUS_W,
  parameter int NWORDS = BLK_W / WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BLK_W-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic [1:0]        blk_cnt,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam int IDX_W = $clog2(NWORDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NWORDS - 1);

  logic [1:0][BLK_W-1:0] ent;
  logic                  wp, rp;
  logic [1:0]            cnt;
  logic [IDX_W-1:0]      idx;
  logic                  hs, pop, push, drop;

  assign hs   = out_valid && out_ready;
  assign pop  = hs && (idx == IDX_LAST);
  // a full buffer still takes a block if the head block retires this cycle
  assign push = in_valid && ((cnt != 2'd2) || pop);
  assign drop = in_valid && (cnt == 2'd2) && !pop;

  assign out_valid = (cnt != 2'd0);
  assign out_last  = out_valid && (idx == IDX_LAST);
  assign blk_cnt   = cnt;
  assign out_data  = ent[rp][idx*WORD_W +: WORD_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent      <= '0;
      wp       <= 1'b0;
      rp       <= 1'b0;
      cnt      <= 2'd0;
      idx      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        ent[wp] <= in_data;
        wp      <= ~wp;
      end
      if (hs) begin
        if (pop) begin
          idx <= '0;
          rp  <= ~rp;
        end else begin
          idx <= idx + 1'b1;
        end
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_kyber_dout_serializer.sv
// Directed bench for kyber_dout_serializer: single block, backpressure, back-to-back,
// overflow drop, full-with-pop acceptance and asynchronous reset mid-block.
module tb_kyber_dout_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [255:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic [1:0]   blk_cnt;
  logic         overflow;
  logic         ovf_clr;

  int n_chk = 0;
  int n_err = 0;

  kyber_dout_serializer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .blk_cnt(blk_cnt), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] blk(input logic [31:0] base);
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[32*i +: 32] = base + 32'(i);
    return b;
  endfunction

  task automatic push_blk(input logic [31:0] base);
    in_valid = 1'b1;
    in_data  = blk(base);
    step();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // drain n words with out_ready high; words of block a then block b
  task automatic drain(input string tag, input logic [31:0] a, input logic [31:0] b, input int n);
    out_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      chk({tag, "_valid"}, 64'(out_valid), 64'(1));
      chk({tag, "_data"}, 64'(out_data), 64'(k < 8 ? a + 32'(k) : b + 32'(k - 8)));
      chk({tag, "_last"}, 64'(out_last), 64'((k % 8) == 7));
      step();
    end
  endtask

  initial begin
    logic [3:0] pat;
    int e;
    int cyc;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; ovf_clr = 1'b0;
    #12;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_last", 64'(out_last), 64'(0));
    chk("rst_cnt", 64'(blk_cnt), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    rst = 1'b0;
    step();

    // single block, next-cycle latency, one word per cycle
    out_ready = 1'b1;
    push_blk(32'h0);
    chk("single_cnt1", 64'(blk_cnt), 64'(1));
    drain("single", 32'h0, 32'h0, 8);
    chk("single_empty", 64'(out_valid), 64'(0));
    chk("single_cnt0", 64'(blk_cnt), 64'(0));

    // backpressure with ready pattern 1,0,0,1
    out_ready = 1'b0;
    push_blk(32'h100);
    pat = 4'b1001;
    e = 0;
    cyc = 0;
    while (e < 8 && cyc < 40) begin
      out_ready = pat[cyc % 4];
      chk("bp_valid", 64'(out_valid), 64'(1));
      chk("bp_data", 64'(out_data), 64'(32'h100 + 32'(e)));
      step();
      if (out_ready) e++;
      cyc++;
    end
    chk("bp_words", 64'(e), 64'(8));
    out_ready = 1'b0;
    chk("bp_empty", 64'(out_valid), 64'(0));

    // back-to-back blocks, then continuous drain
    push_blk(32'h200);
    push_blk(32'h300);
    chk("b2b_cnt2", 64'(blk_cnt), 64'(2));
    drain("b2b", 32'h200, 32'h300, 16);
    chk("b2b_empty", 64'(out_valid), 64'(0));
    chk("b2b_ovf", 64'(overflow), 64'(0));

    // overflow: third block dropped while full and stalled
    out_ready = 1'b0;
    push_blk(32'h200);
    push_blk(32'h300);
    push_blk(32'h400);
    chk("ovf_set", 64'(overflow), 64'(1));
    chk("ovf_cnt", 64'(blk_cnt), 64'(2));
    drain("ovf", 32'h200, 32'h300, 16);
    chk("ovf_empty", 64'(out_valid), 64'(0));
    chk("ovf_sticky", 64'(overflow), 64'(1));
    out_ready = 1'b0;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr", 64'(overflow), 64'(0));

    // full with simultaneous pop accepts the new block
    push_blk(32'h500);
    push_blk(32'h600);
    drain("fp_a", 32'h500, 32'h500, 7);
    chk("fp_last", 64'(out_last), 64'(1));
    chk("fp_a7", 64'(out_data), 64'(32'h507));
    push_blk(32'h700);
    chk("fp_cnt", 64'(blk_cnt), 64'(2));
    chk("fp_ovf", 64'(overflow), 64'(0));
    drain("fp_bc", 32'h600, 32'h700, 16);
    chk("fp_empty", 64'(out_valid), 64'(0));

    // async reset after three words
    push_blk(32'h800);
    drain("rb", 32'h800, 32'h800, 3);
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rb_valid", 64'(out_valid), 64'(0));
    chk("rb_cnt", 64'(blk_cnt), 64'(0));
    chk("rb_last", 64'(out_last), 64'(0));
    chk("rb_data", 64'(out_data), 64'(0));
    #1 rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("rb_idle", 64'(out_valid), 64'(0));
    push_blk(32'h900);
    drain("rb_new", 32'h900, 32'h900, 8);
    chk("rb_empty", 64'(out_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
